// File: rtl/router_write_ctrl.sv
// Write-side packet controller of the 1x3 router: parses headers, steers beats
// into the destination FIFO, checks parity, drops port-3 packets, counts errors.
module router_write_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  write_clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic [2:0]            fifo_full,
  output logic [2:0]            write_inc,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  busy,
  output logic                  pkt_done,
  output logic                  pkt_dropped,
  output logic                  parity_err,
  output logic [CNT_WIDTH-1:0]  err_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    PARITY  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t      state_r;
  logic [1:0]  dest_r;
  logic        drop_r;
  logic [5:0]  len_cnt_r;
  logic [7:0]  par_acc_r;

  logic [1:0]  dest_eff_s;
  logic        drop_eff_s;
  logic        full_eff_s;
  logic        ready_s;
  logic        xfer_s;
  logic [2:0]  winc_s;

  function automatic logic parity_mismatch(input logic [7:0] beat, input logic [7:0] acc);
    return (beat ^ acc) != 8'h00;
  endfunction

  // In IDLE the header on the bus decides routing; afterwards the latched header does.
  always_comb begin
    dest_eff_s = dest_r;
    drop_eff_s = drop_r;
    full_eff_s = 1'b0;
    ready_s    = 1'b0;
    winc_s     = 3'b000;
    if (state_r == IDLE) begin
      dest_eff_s = in_data[1:0];
      drop_eff_s = (in_data[1:0] == 2'd3);
    end else begin
      dest_eff_s = dest_r;
      drop_eff_s = drop_r;
    end
    case (dest_eff_s)
      2'd0:    full_eff_s = fifo_full[0];
      2'd1:    full_eff_s = fifo_full[1];
      2'd2:    full_eff_s = fifo_full[2];
      default: full_eff_s = 1'b0;
    endcase
    if (reset) begin
      ready_s = 1'b0;
    end else begin
      ready_s = drop_eff_s | ~full_eff_s;
    end
    xfer_s = in_valid & ready_s;
    if (xfer_s && !drop_eff_s) begin
      case (dest_eff_s)
        2'd0:    winc_s = 3'b001;
        2'd1:    winc_s = 3'b010;
        2'd2:    winc_s = 3'b100;
        default: winc_s = 3'b000;
      endcase
    end else begin
      winc_s = 3'b000;
    end
  end

  assign in_ready  = ready_s;
  assign write_inc = winc_s;
  assign fifo_data = in_data;

  // Packet FSM with header registers, completion pulses and the error counter.
  always_ff @(posedge write_clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      dest_r      <= 2'd0;
      drop_r      <= 1'b0;
      len_cnt_r   <= 6'd0;
      par_acc_r   <= 8'h00;
      busy        <= 1'b0;
      pkt_done    <= 1'b0;
      pkt_dropped <= 1'b0;
      parity_err  <= 1'b0;
      err_count   <= {CNT_WIDTH{1'b0}};
    end else begin
      pkt_done    <= 1'b0;
      pkt_dropped <= 1'b0;
      parity_err  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (xfer_s) begin
            dest_r    <= in_data[1:0];
            drop_r    <= (in_data[1:0] == 2'd3);
            len_cnt_r <= in_data[7:2];
            par_acc_r <= in_data[7:0];
            busy      <= 1'b1;
            state_r   <= (in_data[7:2] != 6'd0) ? PAYLOAD : PARITY;
          end
        end
        PAYLOAD: begin
          if (xfer_s) begin
            par_acc_r <= par_acc_r ^ in_data[7:0];
            len_cnt_r <= len_cnt_r - 6'd1;
            if (len_cnt_r == 6'd1) begin
              state_r <= PARITY;
            end
          end
        end
        PARITY: begin
          if (xfer_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            if (drop_r) begin
              pkt_dropped <= 1'b1;
            end else begin
              pkt_done <= 1'b1;
              if (parity_mismatch(in_data[7:0], par_acc_r)) begin
                parity_err <= 1'b1;
                if (err_count != CNT_MAX) begin
                  err_count <= err_count + CNT_ONE;
                end
              end
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_write_ctrl.sv
// Self-checking bench: packet-level reference model compared against the
// controller every cycle, plus directed scenarios with literal expectations.
module tb_router_write_ctrl;

  logic       write_clk = 1'b0;
  logic       reset     = 1'b1;
  logic       in_valid  = 1'b0;
  logic [7:0] in_data   = 8'h00;
  logic       in_ready;
  logic [2:0] fifo_full = 3'b000;
  logic [2:0] write_inc;
  logic [7:0] fifo_data;
  logic       busy, pkt_done, pkt_dropped, parity_err;
  logic [7:0] err_count;

  router_write_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
    .write_clk(write_clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .fifo_full(fifo_full), .write_inc(write_inc),
    .fifo_data(fifo_data), .busy(busy), .pkt_done(pkt_done),
    .pkt_dropped(pkt_dropped), .parity_err(parity_err), .err_count(err_count)
  );

  always #5 write_clk = ~write_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Source side
  logic [7:0] src_q[$];
  bit         hold = 1'b0;
  bit         rand_valid = 1'b0;
  bit         rand_full  = 1'b0;

  // Reference model: position inside the current packet and its running XOR
  int         pos = 0;
  logic [7:0] hdr = 8'h00;
  logic [7:0] acc = 8'h00;
  logic [7:0] last_acc = 8'h00;
  bit         m_done = 1'b0, m_drop = 1'b0, m_perr = 1'b0;
  int         m_cnt = 0;

  // Tallies of DUT activity for the literal checks
  int wr_cnt[3];
  int done_cnt, drop_cnt, perr_cnt, stall_cnt, last_steps;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clr_tally();
    for (int i = 0; i < 3; i++) wr_cnt[i] = 0;
    done_cnt = 0; drop_cnt = 0; perr_cnt = 0; stall_cnt = 0;
  endtask

  task automatic model_reset();
    pos = 0; hdr = 8'h00; acc = 8'h00;
    m_done = 1'b0; m_drop = 1'b0; m_perr = 1'b0; m_cnt = 0;
    hold = 1'b0;
    src_q.delete();
  endtask

  task automatic step();
    logic [1:0] d;
    logic       er, x;
    logic [2:0] ew;
    @(negedge write_clk);
    if (rand_full)
      fifo_full = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
    if (!hold) begin
      if (src_q.size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1;
        in_data  = src_q[0];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
    end
    #1;
    d  = (pos == 0) ? in_data[1:0] : hdr[1:0];
    er = !reset && (d == 2'd3 || !fifo_full[d]);
    x  = in_valid && er;
    ew = (x && d != 2'd3) ? (3'b001 << d) : 3'b000;
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("write_inc", 32'(write_inc), 32'(ew));
    chk("fifo_data", 32'(fifo_data), 32'(in_data));
    chk("busy", 32'(busy), 32'(pos != 0));
    chk("pkt_done", 32'(pkt_done), 32'(m_done));
    chk("pkt_dropped", 32'(pkt_dropped), 32'(m_drop));
    chk("parity_err", 32'(parity_err), 32'(m_perr));
    chk("err_count", 32'(err_count), 32'(m_cnt));
    for (int i = 0; i < 3; i++) wr_cnt[i] += int'(write_inc[i]);
    done_cnt  += int'(pkt_done);
    drop_cnt  += int'(pkt_dropped);
    perr_cnt  += int'(parity_err);
    stall_cnt += int'(in_valid && !in_ready);
    @(posedge write_clk);
    m_done = 1'b0; m_drop = 1'b0; m_perr = 1'b0;
    if (!reset) begin
      if (x) begin
        if (pos == 0) begin
          hdr = in_data; acc = in_data; pos = 1;
        end else if (pos <= int'(hdr[7:2])) begin
          acc = acc ^ in_data; pos++;
        end else begin
          last_acc = acc;
          if (hdr[1:0] == 2'd3) m_drop = 1'b1;
          else begin
            m_done = 1'b1;
            if (in_data != acc) begin
              m_perr = 1'b1;
              if (m_cnt < 255) m_cnt++;
            end
          end
          pos = 0;
        end
        void'(src_q.pop_front());
        hold = 1'b0;
      end else begin
        hold = in_valid;
      end
    end
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (src_q.size() > 0 && n < budget) begin step(); n++; end
    chk("drain_timeout", 32'(src_q.size()), 32'd0);
    last_steps = n;
  endtask

  task automatic run_until_pos(input int p, input int budget);
    int n = 0;
    while (pos != p && n < budget) begin step(); n++; end
    chk("pos_timeout", 32'(pos), 32'(p));
  endtask

  task automatic push_pkt(input logic [1:0] addr, input logic [5:0] len, input bit bad);
    logic [7:0] h, p, b;
    h = {len, addr};
    p = h;
    src_q.push_back(h);
    for (int i = 0; i < int'(len); i++) begin
      b = 8'($urandom);
      p = p ^ b;
      src_q.push_back(b);
    end
    if (bad) p = p ^ 8'($urandom_range(1, 255));
    src_q.push_back(p);
  endtask

  task automatic push_bytes(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [7:0] d, input logic [7:0] e, input int n);
    logic [7:0] v[5];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d; v[4] = e;
    for (int i = 0; i < n; i++) src_q.push_back(v[i]);
  endtask

  initial begin
    logic [7:0] b;
    clr_tally();
    model_reset();
    // Reset state
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    reset = 1'b0;
    step();

    // Good packet to port 1
    clr_tally();
    push_bytes(8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDD, 5);
    drain(50); step(); step();
    chk("t1_model_acc", 32'(last_acc), 32'hDD);
    chk("t1_steps", 32'(last_steps), 32'd5);
    chk("t1_wr1", 32'(wr_cnt[1]), 32'd5);
    chk("t1_wr_other", 32'(wr_cnt[0] + wr_cnt[2]), 32'd0);
    chk("t1_done", 32'(done_cnt), 32'd1);
    chk("t1_perr", 32'(perr_cnt), 32'd0);
    chk("t1_err_count", 32'(err_count), 32'd0);

    // Same packet, bad parity
    clr_tally();
    push_bytes(8'h0D, 8'hA1, 8'hB2, 8'hC3, 8'hDC, 5);
    drain(50); step(); step();
    chk("t2_wr1", 32'(wr_cnt[1]), 32'd5);
    chk("t2_done", 32'(done_cnt), 32'd1);
    chk("t2_perr", 32'(perr_cnt), 32'd1);
    chk("t2_err_count", 32'(err_count), 32'd1);

    // Port-3 packet is dropped
    clr_tally();
    push_bytes(8'h0B, 8'h11, 8'h22, 8'h3A, 8'h00, 4);
    drain(50); step(); step();
    chk("t3_stall", 32'(stall_cnt), 32'd0);
    chk("t3_wr", 32'(wr_cnt[0] + wr_cnt[1] + wr_cnt[2]), 32'd0);
    chk("t3_dropped", 32'(drop_cnt), 32'd1);
    chk("t3_done", 32'(done_cnt), 32'd0);
    chk("t3_err_count", 32'(err_count), 32'd1);

    // Port 2, len 4, FIFO 2 full for 5 cycles after 2nd payload beat
    clr_tally();
    push_pkt(2'd2, 6'd4, 1'b0);
    run_until_pos(3, 50);
    fifo_full = 3'b100;
    for (int i = 0; i < 5; i++) begin
      fifo_full[0] = ~fifo_full[0];
      step();
    end
    fifo_full = 3'b000;
    drain(50); step(); step();
    chk("t4_stall", 32'(stall_cnt), 32'd5);
    chk("t4_wr2", 32'(wr_cnt[2]), 32'd6);
    chk("t4_wr0", 32'(wr_cnt[0]), 32'd0);
    chk("t4_done", 32'(done_cnt), 32'd1);
    chk("t4_perr", 32'(perr_cnt), 32'd0);

    // Len-0 packet followed immediately by a len-1 packet
    clr_tally();
    b = 8'($urandom);
    push_bytes(8'h00, 8'h00, 8'h04, b, 8'h04 ^ b, 5);
    drain(50);
    chk("t5_steps", 32'(last_steps), 32'd5);
    step(); step();
    chk("t5_done", 32'(done_cnt), 32'd2);
    chk("t5_wr0", 32'(wr_cnt[0]), 32'd5);

    // Reset mid-packet
    push_bytes(8'h0D, 8'h01, 8'h02, 8'h03, 8'h0D, 5);
    run_until_pos(2, 50);
    @(negedge write_clk);
    reset = 1'b1;
    #1;
    model_reset();
    in_valid = 1'b1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_ready", 32'(in_ready), 32'd0);
    chk("t6_rst_winc", 32'(write_inc), 32'd0);
    step(); step(); step();
    #2 reset = 1'b0;
    clr_tally();
    b = 8'($urandom);
    push_bytes(8'h05, b, 8'h05 ^ b, 8'h00, 8'h00, 3);
    drain(50); step(); step();
    chk("t6_done", 32'(done_cnt), 32'd1);
    chk("t6_wr1", 32'(wr_cnt[1]), 32'd3);
    chk("t6_err_count", 32'(err_count), 32'd0);

    // 256 bad-parity packets under random valid/full saturate the counter
    clr_tally();
    rand_valid = 1'b1;
    rand_full  = 1'b1;
    for (int i = 0; i < 256; i++)
      push_pkt(2'($urandom_range(0, 2)), 6'($urandom_range(0, 3)), 1'b1);
    drain(20000); step(); step();
    chk("t7_perr", 32'(perr_cnt), 32'd256);
    chk("t7_err_count", 32'(err_count), 32'hFF);

    // Random mix of addresses, lengths and parity
    for (int i = 0; i < 60; i++)
      push_pkt(2'($urandom_range(0, 3)), 6'($urandom_range(0, 9)), bit'($urandom_range(0, 1)));
    drain(20000); step(); step();
    chk("t8_err_count", 32'(err_count), 32'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
